linebuffer_ctrl: RTL and testbench

Per-scanline sequencer for the double-buffered line buffer. On each scanline boundary it flips the display/draw buffer pair and clears the new draw buffer to a background colour. It then grants the draw-side ports to the sprite/tile render engine and tracks completion. It sits between the VGA timing generator, the render engine and the line buffer, and is the only driver of the line buffer's `switch` input and draw ports.

---
 rtl/linebuffer_pkg.sv | 18 +
 rtl/lb_clear_gen.sv | 43 ++++
 rtl/linebuffer_ctrl.sv | 147 ++++++++++++++
 tb/tb_linebuffer_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/linebuffer_pkg.sv
// Shared types and widths for the scanline line-buffer sequencer.
package linebuffer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_CLEAR,
        ST_RENDER,
        ST_DONE
    } lb_state_t;

    localparam int TILE_W       = 256;
    localparam int PIX_W        = 16;
    localparam int PIX_PER_TILE = 16;
    localparam int TILE_AW      = 6;
    localparam int PIX_AW       = 10;
    localparam int LINE_W       = 10;
    localparam int CNT_W        = 16;
endpackage

// File: rtl/lb_clear_gen.sv
// Walks the draw buffer tile addresses once, emitting the fill colour replicated per pixel.
module lb_clear_gen
    import linebuffer_pkg::*;
#(
    parameter int TILES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PIX_W-1:0]   i_color,
    output logic               o_busy,
    output logic               o_done,
    output logic [TILE_AW-1:0] o_addr,
    output logic [TILE_W-1:0]  o_data
);
    localparam logic [TILE_AW-1:0] LAST = TILE_AW'(TILES - 1);

    logic               r_busy;
    logic [TILE_AW-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (reset || i_abort) begin
            r_busy <= 1'b0;
            r_addr <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_addr <= '0;
        end else if (r_busy) begin
            if (r_addr == LAST) begin
                r_busy <= 1'b0;
                r_addr <= '0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_addr == LAST);
    assign o_addr = r_addr;
    assign o_data = {PIX_PER_TILE{i_color}};
endmodule

// File: rtl/linebuffer_ctrl.sv
// Per-scanline sequencer: flips the buffer pair, clears the draw side, then hands the
// draw ports to the render engine and tracks completion and overruns.
module linebuffer_ctrl
    import linebuffer_pkg::*;
#(
    parameter int TILES = 64,
    parameter int LINES = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [LINE_W-1:0]  line_num,
    input  logic [PIX_W-1:0]   bg_color,
    output logic               switch,
    output logic [TILE_AW-1:0] addr_tile_draw,
    output logic [TILE_W-1:0]  data_tile_draw,
    output logic               wren_tile_draw,
    output logic [PIX_AW-1:0]  addr_pixel_draw,
    output logic [PIX_W-1:0]   data_pixel_draw,
    output logic               wren_pixel_draw,
    input  logic [TILE_AW-1:0] eng_addr_tile,
    input  logic [TILE_W-1:0]  eng_data_tile,
    input  logic               eng_wren_tile,
    input  logic [PIX_AW-1:0]  eng_addr_pixel,
    input  logic [PIX_W-1:0]   eng_data_pixel,
    input  logic               eng_wren_pixel,
    output logic               draw_start,
    output logic [LINE_W-1:0]  draw_line,
    input  logic               draw_done,
    output logic               line_ready,
    output logic               overrun,
    output logic [CNT_W-1:0]   overrun_count
);
    lb_state_t          r_state;
    logic               r_swap_cnt;
    logic               r_switch;
    logic [PIX_W-1:0]   r_color;
    logic [LINE_W-1:0]  r_draw_line;
    logic               r_draw_start;
    logic               r_line_ready;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_overrun_cnt;

    logic               w_done_ok;
    logic               w_overrun_evt;
    logic               w_clr_start;
    logic               w_clr_busy;
    logic               w_clr_done;
    logic [TILE_AW-1:0] w_clr_addr;
    logic [TILE_W-1:0]  w_clr_data;

    // draw_done on the draw_start cycle belongs to the previous line and is ignored
    assign w_done_ok     = draw_done && !r_draw_start;
    assign w_overrun_evt = line_start &&
                           ((r_state == ST_SWAP) || (r_state == ST_CLEAR) ||
                            ((r_state == ST_RENDER) && !w_done_ok));
    assign w_clr_start   = (r_state == ST_SWAP) && r_swap_cnt && !line_start;

    lb_clear_gen #(.TILES(TILES)) u_clear (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_clr_start),
        .i_abort (line_start),
        .i_color (r_color),
        .o_busy  (w_clr_busy),
        .o_done  (w_clr_done),
        .o_addr  (w_clr_addr),
        .o_data  (w_clr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_swap_cnt    <= 1'b0;
            r_switch      <= 1'b0;
            r_color       <= '0;
            r_draw_line   <= '0;
            r_draw_start  <= 1'b0;
            r_line_ready  <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
        end else if (line_start) begin
            r_state      <= ST_SWAP;
            r_swap_cnt   <= 1'b0;
            r_switch     <= ~r_switch;
            r_color      <= bg_color;
            r_draw_line  <= (line_num == LINE_W'(LINES - 1)) ? '0 : line_num + 1'b1;
            r_draw_start <= 1'b0;
            r_line_ready <= 1'b0;
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
                if (r_overrun_cnt != '1)
                    r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
        end else begin
            r_draw_start <= 1'b0;
            case (r_state)
                ST_SWAP: begin
                    r_swap_cnt <= 1'b1;
                    if (r_swap_cnt)
                        r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (w_clr_done) begin
                        r_state      <= ST_RENDER;
                        r_draw_start <= 1'b1;
                    end
                end
                ST_RENDER: begin
                    if (w_done_ok) begin
                        r_state      <= ST_DONE;
                        r_line_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_tile_draw  = '0;
        data_tile_draw  = '0;
        wren_tile_draw  = 1'b0;
        addr_pixel_draw = '0;
        data_pixel_draw = '0;
        wren_pixel_draw = 1'b0;
        if (r_state == ST_CLEAR) begin
            addr_tile_draw = w_clr_addr;
            data_tile_draw = w_clr_data;
            wren_tile_draw = w_clr_busy;
        end else if (r_state == ST_RENDER) begin
            addr_tile_draw  = eng_addr_tile;
            data_tile_draw  = eng_data_tile;
            wren_tile_draw  = eng_wren_tile;
            addr_pixel_draw = eng_addr_pixel;
            data_pixel_draw = eng_data_pixel;
            wren_pixel_draw = eng_wren_pixel;
        end
    end

    assign switch        = r_switch;
    assign draw_start    = r_draw_start;
    assign draw_line     = r_draw_line;
    assign line_ready    = r_line_ready;
    assign overrun       = r_overrun;
    assign overrun_count = r_overrun_cnt;
endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl: table of full-line sequences plus overrun/reset corners.
module tb_linebuffer_ctrl;
    logic         clk = 1'b0;
    logic         reset;
    logic         line_start;
    logic [9:0]   line_num;
    logic [15:0]  bg_color;
    logic         switch;
    logic [5:0]   addr_tile_draw;
    logic [255:0] data_tile_draw;
    logic         wren_tile_draw;
    logic [9:0]   addr_pixel_draw;
    logic [15:0]  data_pixel_draw;
    logic         wren_pixel_draw;
    logic [5:0]   eng_addr_tile;
    logic [255:0] eng_data_tile;
    logic         eng_wren_tile;
    logic [9:0]   eng_addr_pixel;
    logic [15:0]  eng_data_pixel;
    logic         eng_wren_pixel;
    logic         draw_start;
    logic [9:0]   draw_line;
    logic         draw_done;
    logic         line_ready;
    logic         overrun;
    logic [15:0]  overrun_count;

    linebuffer_ctrl #(.TILES(64), .LINES(480)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
        .bg_color(bg_color), .switch(switch),
        .addr_tile_draw(addr_tile_draw), .data_tile_draw(data_tile_draw),
        .wren_tile_draw(wren_tile_draw), .addr_pixel_draw(addr_pixel_draw),
        .data_pixel_draw(data_pixel_draw), .wren_pixel_draw(wren_pixel_draw),
        .eng_addr_tile(eng_addr_tile), .eng_data_tile(eng_data_tile),
        .eng_wren_tile(eng_wren_tile), .eng_addr_pixel(eng_addr_pixel),
        .eng_data_pixel(eng_data_pixel), .eng_wren_pixel(eng_wren_pixel),
        .draw_start(draw_start), .draw_line(draw_line), .draw_done(draw_done),
        .line_ready(line_ready), .overrun(overrun), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  ln;
        logic [15:0] bg;
        logic [9:0]  exp_line;
    } vec_t;

    vec_t         tbl[4];
    int           n_vec = 0;
    int           n_err = 0;
    logic         exp_sw = 1'b0;
    logic [255:0] exp_fill;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " switch"},     256'(switch), 256'(0));
        chk({tag, " tile_draw"},  {addr_tile_draw, wren_tile_draw} == 7'd0 && data_tile_draw == '0 ? 256'(1) : 256'(0), 256'(1));
        chk({tag, " pixel_draw"}, 256'({addr_pixel_draw, data_pixel_draw, wren_pixel_draw}), 256'(0));
        chk({tag, " draw_start"}, 256'(draw_start), 256'(0));
        chk({tag, " draw_line"},  256'(draw_line), 256'(0));
        chk({tag, " line_ready"}, 256'(line_ready), 256'(0));
        chk({tag, " overrun"},    256'(overrun), 256'(0));
        chk({tag, " ovr_count"},  256'(overrun_count), 256'(0));
    endtask

    // Pulses line_start during the current cycle; returns in cycle T+1 before its negedge
    task automatic pulse_line(input logic [9:0] ln, input logic [15:0] bg);
        line_start = 1'b1;
        line_num   = ln;
        bg_color   = bg;
        tick();
        line_start = 1'b0;
        exp_sw     = ~exp_sw;
    endtask

    initial begin
        tbl[0] = '{ln: 10'd5,   bg: 16'h1234, exp_line: 10'd6};
        tbl[1] = '{ln: 10'd479, bg: 16'hABCD, exp_line: 10'd0};
        tbl[2] = '{ln: 10'd0,   bg: 16'h0000, exp_line: 10'd1};
        tbl[3] = '{ln: 10'd478, bg: 16'hFFFF, exp_line: 10'd479};

        reset = 1'b1; line_start = 1'b0; line_num = '0; bg_color = '0; draw_done = 1'b0;
        eng_addr_tile = '0; eng_data_tile = '0; eng_wren_tile = 1'b0;
        eng_addr_pixel = '0; eng_data_pixel = '0; eng_wren_pixel = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_reset_vals("reset");
        tick();
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            exp_fill = {16{tbl[v].bg}};
            pulse_line(tbl[v].ln, tbl[v].bg);
            @(negedge clk);
            chk("switch T+1", 256'(switch), 256'(exp_sw));
            chk("no overrun from idle/done", 256'(overrun), 256'(0));
            tick(); tick();
            for (int i = 0; i < 64; i++) begin
                eng_wren_tile  = 1'b1; eng_addr_tile  = 6'd5; eng_data_tile = {8{32'hDEADBEEF}};
                eng_wren_pixel = 1'b1; eng_addr_pixel = 10'd37;
                @(negedge clk);
                chk("clear wren", 256'(wren_tile_draw), 256'(1));
                chk("clear addr", 256'(addr_tile_draw), 256'(i));
                chk("clear data", data_tile_draw, exp_fill);
                chk("clear pix blocked", 256'(wren_pixel_draw), 256'(0));
                tick();
            end
            eng_wren_tile  = 1'b0;
            eng_wren_pixel = 1'b1; eng_addr_pixel = 10'd37; eng_data_pixel = 16'h5A5A;
            draw_done = 1'b1;
            @(negedge clk);
            chk("draw_start T+67", 256'(draw_start), 256'(1));
            chk("draw_line", 256'(draw_line), 256'(tbl[v].exp_line));
            chk("pass wren_pixel", 256'(wren_pixel_draw), 256'(1));
            chk("pass addr_pixel", 256'(addr_pixel_draw), 256'(37));
            chk("pass data_pixel", 256'(data_pixel_draw), 256'(16'h5A5A));
            tick();
            draw_done = 1'b0;
            @(negedge clk);
            chk("draw_start one cycle", 256'(draw_start), 256'(0));
            chk("done on start ignored", 256'(line_ready), 256'(0));
            draw_done = 1'b1;
            tick();
            draw_done = 1'b0;
            @(negedge clk);
            chk("line_ready D+1", 256'(line_ready), 256'(1));
            chk("done pix blocked", 256'(wren_pixel_draw), 256'(0));
            eng_wren_pixel = 1'b0;
            tick();
        end

        // Overrun: RENDER never finishes before the next line_start
        pulse_line(10'd10, 16'h0F0F);
        @(negedge clk);
        chk("pre-overrun flag", 256'(overrun), 256'(0));
        repeat (66) tick();
        @(negedge clk);
        chk("ovr seq draw_start", 256'(draw_start), 256'(1));
        tick();
        pulse_line(10'd11, 16'h3333);
        @(negedge clk);
        chk("overrun set", 256'(overrun), 256'(1));
        chk("overrun_count 1", 256'(overrun_count), 256'(1));
        chk("overrun switch", 256'(switch), 256'(exp_sw));
        chk("overrun draw_line", 256'(draw_line), 256'(12));
        tick(); tick();
        @(negedge clk);
        chk("new clear wren", 256'(wren_tile_draw), 256'(1));
        chk("new clear addr", 256'(addr_tile_draw), 256'(0));
        chk("new clear data", data_tile_draw, {16{16'h3333}});

        // draw_done coinciding with line_start completes the line
        repeat (64) tick();
        @(negedge clk);
        chk("sim seq draw_start", 256'(draw_start), 256'(1));
        tick();
        draw_done = 1'b1;
        pulse_line(10'd100, 16'h7777);
        draw_done = 1'b0;
        @(negedge clk);
        chk("simul count unchanged", 256'(overrun_count), 256'(1));
        chk("overrun sticky", 256'(overrun), 256'(1));
        chk("simul switch", 256'(switch), 256'(exp_sw));
        chk("simul draw_line", 256'(draw_line), 256'(101));
        tick(); tick();
        repeat (10) tick();
        @(negedge clk);
        chk("mid clear addr", 256'(addr_tile_draw), 256'(10));
        chk("mid clear wren", 256'(wren_tile_draw), 256'(1));

        // Reset mid-CLEAR
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid-clear reset");
        begin
            logic stray = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (wren_tile_draw || draw_start || switch) stray = 1'b1;
            end
            chk("idle after reset", 256'(stray), 256'(0));
        end
        tick();
        exp_sw = 1'b0;
        pulse_line(10'd20, 16'h2222);
        @(negedge clk);
        chk("idle start switch", 256'(switch), 256'(1));
        chk("idle start no overrun", 256'(overrun), 256'(0));
        chk("idle start draw_line", 256'(draw_line), 256'(21));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
